glycemic_arbiter: RTL and testbench
===================================

GLYCEMIC_ARBITER -- requirements
Module: glycemic_arbiter

Interface
REQ-001 Parameter: LOW_MAX, default 2, highest ones-count classified LOW.
REQ-002 Parameter: HIGH_MIN, default 6, lowest ones-count classified HIGH; LOW_MAX < HIGH_MIN SHALL hold.
REQ-003 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  4  per-requester sample request; requester i SHALL hold req[i] and its data slice stable until gnt[i].
REQ-006 Port: data  in  32  requester i sample in bits [8i+7:8i].
REQ-007 Port: gnt  out  4  one-hot, one-cycle pulse marking acceptance of that requester's sample.
REQ-008 Port: res_valid  out  1  result available.
REQ-009 Port: res_ready  in  1  downstream accepts result.
REQ-010 Port: res_id  out  2  index of the requester that produced the result.
REQ-011 Port: res_count  out  4  number of ones in the accepted sample, 0..8.
REQ-012 Port: res_level  out  2  classification: 0 LOW, 1 NORMAL, 2 HIGH; value 3 SHALL never be driven.
REQ-013 Port: sample_cnt  out  8  completed result handshakes, modulo 256.

Function
REQ-014 The FSM SHALL have three states: IDLE, COUNT and OUTPUT.
REQ-015 In IDLE, when any req bit is 1, the block SHALL pulse gnt for the winner, latch its data byte and its id, and go to COUNT; when no req bit is 1 it SHALL stay in IDLE.
REQ-016 The winner SHALL be the first set req bit scanning upward from rr_ptr, wrapping from 3 to 0.
REQ-017 In COUNT, the block SHALL register the popcount of the latched byte into res_count and the classification into res_level, then go to OUTPUT.
REQ-018 Classification SHALL be: count <= LOW_MAX gives LOW; count >= HIGH_MIN gives HIGH; any other count gives NORMAL.
REQ-019 In OUTPUT, res_valid SHALL be 1 and res_id, res_count and res_level SHALL stay stable until res_valid and res_ready are both 1.
REQ-020 On that handshake, the block SHALL go to IDLE, set rr_ptr to (res_id+1) mod 4, and increment sample_cnt, wrapping 255 to 0.
REQ-021 Latency: gnt in cycle N SHALL give res_valid in cycle N+2; the minimum spacing between successive grants SHALL be 3 cycles.
REQ-022 gnt SHALL be 0 in every state except the IDLE grant cycle; at most one gnt bit SHALL be 1 in any cycle.
REQ-023 res_ready while res_valid is 0 SHALL have no effect.
REQ-024 Deassertion of req[i] after its grant SHALL NOT affect the in-flight result.
REQ-025 A req bit that drops without being granted SHALL be ignored, with no pending memory.
REQ-026 res_count SHALL be exact for all 256 byte values: 0x00 gives 0 and 0xFF gives 8.

Reset
REQ-027 While rst is 1, the block SHALL immediately force: state IDLE, gnt 0, res_valid 0, res_id 0, res_count 0, res_level 0, sample_cnt 0, rr_ptr 0, latched byte 0.
REQ-028 Reset asserted in COUNT or OUTPUT SHALL discard the in-flight sample; no result or count increment SHALL appear after release.
REQ-029 The first grant after reset release SHALL occur no earlier than the first rising edge with rst at 0.

Structure
REQ-030 A shared package SHALL hold: the state encoding (IDLE, COUNT, OUTPUT); the level encoding (LOW=0, NORMAL=1, HIGH=2); the requester count (4); and the sample width (8).
REQ-031 The design SHALL contain one sub-module, glycemic_popcount: combinational, 8-bit in, 4-bit ones count out, instantiated once and shared by all requesters.
REQ-032 Round-robin selection and classification SHALL be implemented in glycemic_arbiter, not in the sub-module.

Verification
REQ-033 Scenario: req=0001, data[7:0]=0xB5, res_ready=1 -> gnt=0001 at N; res_valid at N+2 with id 0, count 5, level NORMAL; sample_cnt becomes 1.
REQ-034 Scenario: req=1111 held, res_ready=1 -> grants in order 0,1,2,3,0; with bytes 0x00, 0xFF, 0x07, 0x3F the results are count 0 LOW, 8 HIGH, 3 NORMAL, 6 HIGH.
REQ-035 Scenario: res_ready=0 for 5 cycles in OUTPUT, with other reqs active -> outputs stable, no gnt pulse; handshake on cycle 6, then the next grant 1 cycle later.
REQ-036 Scenario: rst pulsed in COUNT with req=0100 -> res_valid stays 0, sample_cnt stays 0, rr_ptr resets; after release req[2] is granted again.
REQ-037 Scenario: 256 handshakes -> sample_cnt wraps to 0; exhaustive sweep of data 0x00..0xFF on requester 3 -> res_count matches the reference popcount for every value.
REQ-038 Scenario: req[1] pulsed for 1 cycle while in OUTPUT and then dropped -> no grant to requester 1 afterwards.

Source files
------------

// File: rtl/glycemic_arbiter_pkg.sv
// Shared definitions for the glycemic arbiter: FSM and level encodings,
// requester count and sample geometry.
package glycemic_arbiter_pkg;

    localparam int NUM_REQ  = 4;
    localparam int SAMPLE_W = 8;
    localparam int ID_W     = 2;
    localparam int CNT_W    = 4;
    localparam int SCNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LVL_LOW    = 2'd0,
        LVL_NORMAL = 2'd1,
        LVL_HIGH   = 2'd2
    } level_t;

    // Round-robin successor of a requester index; wraps 3 -> 0 naturally.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return id + ID_W'(1);
    endfunction

endpackage

// File: rtl/glycemic_arbiter_if.sv
// Request/grant and result handshake bundle between requesters, the
// arbiter and the downstream result consumer.
interface glycemic_arbiter_if;
    import glycemic_arbiter_pkg::*;

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*SAMPLE_W-1:0] data;
    logic [NUM_REQ-1:0]          gnt;
    logic                        res_valid;
    logic                        res_ready;
    logic [ID_W-1:0]             res_id;
    logic [CNT_W-1:0]            res_count;
    logic [1:0]                  res_level;
    logic [SCNT_W-1:0]           sample_cnt;

    // Requester/consumer side.
    modport master (
        output req, data, res_ready,
        input  gnt, res_valid, res_id, res_count, res_level, sample_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, data, res_ready,
        output gnt, res_valid, res_id, res_count, res_level, sample_cnt
    );

endinterface

// File: rtl/glycemic_popcount.sv
// Combinational ones-count of one sample byte.
module glycemic_popcount
    import glycemic_arbiter_pkg::*;
(
    input  logic [SAMPLE_W-1:0] din,
    output logic [CNT_W-1:0]    count
);

    // Sum the bits of the sample.
    always_comb begin
        count = '0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            count = count + CNT_W'(din[i]);
        end
    end

endmodule

// File: rtl/glycemic_arbiter.sv
// Round-robin arbiter that accepts one sample byte at a time from four
// requesters, counts its ones, classifies the count and presents the
// result on a valid/ready handshake.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for any req; grant pulse and byte/id latch here
//   ST_COUNT  | register popcount and level of the latched byte
//   ST_OUTPUT | res_valid high, result held until res_ready
//
// LOW_MAX must be below HIGH_MIN for the three levels to be distinct.
module glycemic_arbiter
    import glycemic_arbiter_pkg::*;
#(
    parameter int LOW_MAX  = 2,
    parameter int HIGH_MIN = 6
) (
    input logic               clk,
    input logic               rst,
    glycemic_arbiter_if.slave bus
);

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     scan_id;
    logic                any_req;
    logic [NUM_REQ-1:0]  gnt_int;
    logic [SAMPLE_W-1:0] sample;
    logic [CNT_W-1:0]    pop_count;
    logic [ID_W-1:0]     res_id;
    logic [CNT_W-1:0]    res_count;
    level_t              res_level;
    logic [SCNT_W-1:0]   sample_cnt;
    logic                handshake;

    function automatic level_t classify(input logic [CNT_W-1:0] cnt);
        if (int'(cnt) <= LOW_MAX) begin
            return LVL_LOW;
        end else if (int'(cnt) >= HIGH_MIN) begin
            return LVL_HIGH;
        end
        return LVL_NORMAL;
    endfunction

    glycemic_popcount u_popcount (
        .din   (sample),
        .count (pop_count)
    );

    // Winner is the first set req bit at or above rr_ptr, wrapping 3 -> 0.
    always_comb begin
        win_id  = rr_ptr;
        any_req = 1'b0;
        scan_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_id = rr_ptr + ID_W'(k);
            if (!any_req && bus.req[scan_id]) begin
                any_req = 1'b1;
                win_id  = scan_id;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant pulse; grant is gated by rst so it stays low
    // for the whole reset interval even with requests pending.
    always_comb begin
        state_nxt = state;
        gnt_int   = '0;
        case (state)
            ST_IDLE: begin
                if (any_req && !rst) begin
                    gnt_int[win_id] = 1'b1;
                    state_nxt       = ST_COUNT;
                end
            end
            ST_COUNT: begin
                state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign handshake = (state == ST_OUTPUT) && bus.res_ready;

    // Datapath: latch winner byte/id, register count/level, advance the
    // round-robin pointer and the completion counter on each handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample     <= '0;
            res_id     <= '0;
            res_count  <= '0;
            res_level  <= LVL_LOW;
            rr_ptr     <= '0;
            sample_cnt <= '0;
        end else begin
            if (state == ST_IDLE && any_req) begin
                sample <= bus.data[int'(win_id)*SAMPLE_W +: SAMPLE_W];
                res_id <= win_id;
            end
            if (state == ST_COUNT) begin
                res_count <= pop_count;
                res_level <= classify(pop_count);
            end
            if (handshake) begin
                rr_ptr     <= next_id(res_id);
                sample_cnt <= sample_cnt + SCNT_W'(1);
            end
        end
    end

    assign bus.gnt        = gnt_int;
    assign bus.res_valid  = (state == ST_OUTPUT);
    assign bus.res_id     = res_id;
    assign bus.res_count  = res_count;
    assign bus.res_level  = res_level;
    assign bus.sample_cnt = sample_cnt;

endmodule

// File: tb/tb_glycemic_arbiter.sv
// Self-checking bench for glycemic_arbiter: scenario tasks plus a
// scoreboard monitor that predicts each result at grant time.
module tb_glycemic_arbiter;
    import glycemic_arbiter_pkg::*;

    localparam int REF_LOW_MAX  = 2;
    localparam int REF_HIGH_MIN = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    glycemic_arbiter_if bus ();

    glycemic_arbiter #(
        .LOW_MAX  (REF_LOW_MAX),
        .HIGH_MIN (REF_HIGH_MIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [3:0] cnt;
        logic [1:0] lvl;
        int         gcyc;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    logic [7:0] tb_cnt      = 8'd0;
    logic       prev_valid  = 1'b0;
    logic       prev_ready  = 1'b0;
    logic [1:0] prev_id     = 2'd0;
    logic [3:0] prev_cnt    = 4'd0;
    logic [1:0] prev_lvl    = 2'd0;
    int         mon_gi;
    logic [7:0] mon_byte;
    exp_t       mon_e;
    logic [3:0] g;
    int         n;
    bit         ok;

    function automatic logic [3:0] ref_pop(input logic [7:0] b);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) if (b[i]) c++;
        return 4'(c);
    endfunction

    function automatic logic [1:0] ref_level(input logic [3:0] c);
        if (int'(c) <= REF_LOW_MAX) return 2'd0;
        if (int'(c) >= REF_HIGH_MIN) return 2'd2;
        return 2'd1;
    endfunction

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            sb.delete();
            tb_cnt     = 8'd0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            vectors++;
            if (bus.sample_cnt !== tb_cnt) begin
                miscompares++;
                $display("FAIL sample_cnt: got %0d expected %0d", bus.sample_cnt, tb_cnt);
            end
            if (bus.gnt !== 4'b0000) begin
                vectors++;
                if ($countones(bus.gnt) != 1 || bus.res_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gnt_onehot: got gnt %b valid %b expected one-hot gnt, valid 0",
                             bus.gnt, bus.res_valid);
                end else begin
                    mon_gi = 0;
                    for (int i = 0; i < 4; i++) if (bus.gnt[i]) mon_gi = i;
                    mon_byte   = bus.data[8*mon_gi +: 8];
                    mon_e.id   = 2'(mon_gi);
                    mon_e.cnt  = ref_pop(mon_byte);
                    mon_e.lvl  = ref_level(mon_e.cnt);
                    mon_e.gcyc = cyc;
                    sb.push_back(mon_e);
                end
            end
            if (bus.res_valid === 1'b1 && !prev_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL result_spurious: got res_valid 1 expected no result pending");
                end else if (cyc != sb[0].gcyc + 2) begin
                    miscompares++;
                    $display("FAIL latency: got %0d cycles expected 2", cyc - sb[0].gcyc);
                end
            end
            if (bus.res_valid === 1'b1 && prev_valid && !prev_ready) begin
                vectors++;
                if (bus.res_id !== prev_id || bus.res_count !== prev_cnt || bus.res_level !== prev_lvl) begin
                    miscompares++;
                    $display("FAIL result_hold: got %0d/%0d/%0d expected %0d/%0d/%0d",
                             bus.res_id, bus.res_count, bus.res_level, prev_id, prev_cnt, prev_lvl);
                end
            end
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL result_unexpected: got id %0d count %0d expected nothing",
                             bus.res_id, bus.res_count);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.res_id !== mon_e.id || bus.res_count !== mon_e.cnt || bus.res_level !== mon_e.lvl) begin
                        miscompares++;
                        $display("FAIL result: got id %0d count %0d level %0d expected id %0d count %0d level %0d",
                                 bus.res_id, bus.res_count, bus.res_level, mon_e.id, mon_e.cnt, mon_e.lvl);
                    end
                end
                tb_cnt = tb_cnt + 8'd1;
            end
            prev_valid = (bus.res_valid === 1'b1);
            prev_ready = (bus.res_ready === 1'b1);
            prev_id    = bus.res_id;
            prev_cnt   = bus.res_count;
            prev_lvl   = bus.res_level;
        end
    end

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output logic [3:0] gw, output int nw);
        gw = 4'b0000;
        nw = 0;
        while (nw < 20) begin
            @(negedge clk);
            nw++;
            if (bus.gnt !== 4'b0000) begin
                gw = bus.gnt;
                break;
            end
        end
    endtask

    task automatic wait_valid(output bit okw);
        okw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                okw = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(output bit okd);
        okd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.res_valid === 1'b0 && bus.gnt === 4'b0000) begin
                okd = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req       = 4'b1111;
        bus.data      = 32'hA5A5_A5A5;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.res_valid); end
        vectors++; if (bus.res_id !== 2'd0) begin miscompares++; $display("FAIL reset_id: got %0d expected 0", bus.res_id); end
        vectors++; if (bus.res_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.res_count); end
        vectors++; if (bus.res_level !== 2'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", bus.res_level); end
        vectors++; if (bus.sample_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_sample_cnt: got %0d expected 0", bus.sample_cnt); end
        next_drive();
        bus.req = 4'b0000;
        rst     = 1'b0;
        @(negedge clk);
        vectors++; if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin
            miscompares++; $display("FAIL idle_no_req: got gnt %b valid %b expected 0000 0", bus.gnt, bus.res_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        next_drive();
        bus.res_ready = 1'b1;
        bus.data      = {8'h3F, 8'h07, 8'hFF, 8'h00};
        bus.req       = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g, n);
            exp_g = 4'b0001 << (i % 4);
            vectors++; if (g !== exp_g) begin miscompares++; $display("FAIL rr_grant%0d: got %b expected %b", i, g, exp_g); end
            if (i > 0) begin
                vectors++; if (n != 3) begin miscompares++; $display("FAIL rr_spacing%0d: got %0d expected 3", i, n); end
            end
            next_drive();
        end
        bus.req = 4'b0000;
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rr_drain: got pending result expected idle"); end
    endtask

    task automatic test_single();
        next_drive();
        bus.res_ready = 1'b1;
        bus.data      = 32'h0000_00B5;
        bus.req       = 4'b0001;
        wait_gnt(g, n);
        vectors++; if (g !== 4'b0001 || n != 1) begin miscompares++; $display("FAIL single_gnt: got %b after %0d expected 0001 after 1", g, n); end
        next_drive();
        bus.req  = 4'b0000;
        bus.data = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_count !== 4'd5 || bus.res_level !== 2'd1) begin
            miscompares++;
            $display("FAIL single_result: got v%b id %0d count %0d level %0d expected v1 id 0 count 5 level 1",
                     bus.res_valid, bus.res_id, bus.res_count, bus.res_level);
        end
        @(negedge clk);
        vectors++; if (bus.sample_cnt !== 8'd6 || bus.res_valid !== 1'b0) begin
            miscompares++; $display("FAIL single_cnt: got cnt %0d valid %b expected 6 0", bus.sample_cnt, bus.res_valid);
        end
    endtask

    task automatic test_backpressure();
        next_drive();
        bus.res_ready = 1'b0;
        bus.data      = 32'h0000_8100;
        bus.req       = 4'b0010;
        wait_gnt(g, n);
        vectors++; if (g !== 4'b0010) begin miscompares++; $display("FAIL bp_gnt: got %b expected 0010", g); end
        next_drive();
        bus.req = 4'b1101;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_valid_timeout: got no res_valid expected res_valid"); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            vectors++; if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b1) begin
                miscompares++; $display("FAIL bp_stall%0d: got gnt %b valid %b expected 0000 1", i, bus.gnt, bus.res_valid);
            end
        end
        next_drive();
        bus.res_ready = 1'b1;
        @(negedge clk);
        vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_handshake: got valid %b expected 1", bus.res_valid); end
        @(negedge clk);
        vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL bp_next_gnt: got %b expected 0100", bus.gnt); end
        next_drive();
        bus.req = 4'b0000;
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_drain: got pending result expected idle"); end
    endtask

    task automatic test_drop_no_memory();
        logic [3:0] seen;
        next_drive();
        bus.res_ready = 1'b0;
        bus.data      = 32'h0000_0003;
        bus.req       = 4'b0001;
        wait_gnt(g, n);
        vectors++; if (g !== 4'b0001) begin miscompares++; $display("FAIL drop_gnt: got %b expected 0001", g); end
        next_drive();
        bus.req = 4'b0000;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL drop_valid_timeout: got no res_valid expected res_valid"); end
        next_drive();
        bus.req = 4'b0010;
        next_drive();
        bus.req = 4'b0000;
        next_drive();
        bus.res_ready = 1'b1;
        seen = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen = seen | bus.gnt;
        end
        vectors++; if (seen !== 4'b0000) begin miscompares++; $display("FAIL drop_no_memory: got gnt %b expected 0000", seen); end
    endtask

    task automatic test_reset_in_count();
        next_drive();
        bus.res_ready = 1'b1;
        bus.data      = 32'h00F0_0000;
        bus.req       = 4'b0100;
        wait_gnt(g, n);
        vectors++; if (g !== 4'b0100) begin miscompares++; $display("FAIL rstc_gnt: got %b expected 0100", g); end
        next_drive();
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (bus.res_valid !== 1'b0 || bus.sample_cnt !== 8'd0 || bus.gnt !== 4'b0000) begin
            miscompares++; $display("FAIL rstc_in_reset: got v%b cnt %0d gnt %b expected v0 cnt 0 gnt 0000",
                                    bus.res_valid, bus.sample_cnt, bus.gnt);
        end
        next_drive();
        rst     = 1'b0;
        bus.req = 4'b1100;
        @(negedge clk);
        vectors++; if (bus.gnt !== 4'b0100 || bus.res_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstc_regrant: got gnt %b valid %b expected 0100 0", bus.gnt, bus.res_valid);
        end
        next_drive();
        bus.req = 4'b0000;
        drain(ok);
        vectors++; if (!ok || bus.sample_cnt !== 8'd1) begin
            miscompares++; $display("FAIL rstc_after: got drained %0d cnt %0d expected 1 1", ok, bus.sample_cnt);
        end
    endtask

    task automatic test_sweep();
        next_drive();
        rst     = 1'b1;
        bus.req = 4'b0000;
        next_drive();
        rst           = 1'b0;
        bus.res_ready = 1'b1;
        for (int v = 0; v < 256; v++) begin
            bus.data = {8'(v), 24'h5A_5A5A};
            bus.req  = 4'b1000;
            wait_gnt(g, n);
            vectors++; if (g !== 4'b1000) begin miscompares++; $display("FAIL sweep_gnt%0d: got %b expected 1000", v, g); end
            next_drive();
        end
        bus.req = 4'b0000;
        drain(ok);
        vectors++; if (!ok || bus.sample_cnt !== 8'd0) begin
            miscompares++; $display("FAIL sweep_wrap: got drained %0d cnt %0d expected 1 0", ok, bus.sample_cnt);
        end
    endtask

    initial begin
        bus.req       = 4'b0000;
        bus.data      = 32'h0;
        bus.res_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_drop_no_memory();
        test_reset_in_count();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
